// File: rtl/up_wishbone_pipelined.sv
// rtl/up_wishbone_pipelined.sv - pipelined Wishbone B4 slave to uP register-bus bridge; optional ack timeout via UP_WISHBONE_TIMEOUT_EN
module up_wishbone_pipelined #(
    parameter int  WISHBONE_ADDRESS_WIDTH = 16,
    parameter int  BUS_WIDTH              = 4,
    parameter int  FIFO_DEPTH             = 4,
    parameter int  TIMEOUT_CYCLES         = 255,
    localparam int UP_ADDR_WIDTH          = WISHBONE_ADDRESS_WIDTH - $clog2(BUS_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_wb_cyc,
    input  logic                              s_wb_stb,
    input  logic                              s_wb_we,
    input  logic [WISHBONE_ADDRESS_WIDTH-1:0] s_wb_addr,
    input  logic [8*BUS_WIDTH-1:0]            s_wb_data_i,
    input  logic [BUS_WIDTH-1:0]              s_wb_sel_i,
    output logic                              s_wb_stall,
    output logic                              s_wb_ack,
    output logic                              s_wb_err,
    output logic [8*BUS_WIDTH-1:0]            s_wb_data_o,
    output logic                              up_rreq,
    input  logic                              up_rack,
    output logic [UP_ADDR_WIDTH-1:0]          up_raddr,
    input  logic [8*BUS_WIDTH-1:0]            up_rdata,
    output logic                              up_wreq,
    input  logic                              up_wack,
    output logic [UP_ADDR_WIDTH-1:0]          up_waddr,
    output logic [8*BUS_WIDTH-1:0]            up_wdata,
    output logic [BUS_WIDTH-1:0]              up_wstrb
);
    localparam int DW  = 8 * BUS_WIDTH;
    localparam int LSB = $clog2(BUS_WIDTH);
    localparam int PW  = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_fifo_we   [FIFO_DEPTH];
    logic [UP_ADDR_WIDTH-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DW-1:0]            r_fifo_data [FIFO_DEPTH];
    logic [BUS_WIDTH-1:0]     r_fifo_sel  [FIFO_DEPTH];
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [PW:0]              r_count;
    logic                     r_we;
    logic [UP_ADDR_WIDTH-1:0] r_addr;
    logic [DW-1:0]            r_wdata;
    logic [BUS_WIDTH-1:0]     r_wstrb;
    logic                     r_ack;
    logic [DW-1:0]            r_data_o;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_abort;
    logic                     w_match;
    logic                     w_expire;
    logic                     w_done_ack;

    // Reject parameter sets the pointer arithmetic and address split cannot handle
    if (BUS_WIDTH < 1 || (BUS_WIDTH & (BUS_WIDTH - 1)) != 0 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("up_wishbone_pipelined: illegal parameter set");
    end

    // Byte-lane address bits are not forwarded; the uP bus is word addressed
    if (LSB > 0) begin : g_addr_lsb
        logic w_unused_addr_lsb;
        assign w_unused_addr_lsb = ^s_wb_addr[LSB-1:0];
    end

    assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign s_wb_stall = w_full | rst;
    assign w_push     = s_wb_cyc & s_wb_stb & ~w_full;
    // Dropping cyc kills everything queued or in flight, but only when there is something to kill
    assign w_abort    = ~s_wb_cyc & (~w_empty | (r_state == ST_REQ));
    assign w_match    = (r_state == ST_REQ) & (r_we ? up_wack : up_rack);

    assign s_wb_ack    = r_ack;
    assign s_wb_data_o = r_data_o;
    assign up_raddr    = r_addr;
    assign up_waddr    = r_addr;
    assign up_wdata    = r_wdata;
    assign up_wstrb    = r_wstrb;

`ifdef UP_WISHBONE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;
    logic          w_done_err;

    // Count clocks spent in REQ; cleared whenever a new request is loaded
    always_ff @(posedge clk) begin
        if (rst || w_pop) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_REQ && !w_match && !w_expire) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_expire   = (r_state == ST_REQ) & (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    // A matching ack on the expiry edge still wins over the error
    assign w_done_err = ~w_abort & w_expire & ~w_match;

    // Error termination pulse for a request the uP never answered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_done_err;
        end
    end

    assign s_wb_err = r_err;
`else
    assign w_expire = 1'b0;
    assign s_wb_err = 1'b0;
`endif

    // Command FIFO storage; contents are don't-care until the count covers them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_we[r_wr_ptr]   <= s_wb_we;
            r_fifo_addr[r_wr_ptr] <= s_wb_addr[WISHBONE_ADDRESS_WIDTH-1:LSB];
            r_fifo_data[r_wr_ptr] <= s_wb_data_i;
            r_fifo_sel[r_wr_ptr]  <= s_wb_sel_i;
        end
    end

    // FIFO pointers and occupancy; an abort flushes like a reset
    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Issue FSM next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (!w_empty)            w_state_nxt = ST_REQ;
                ST_REQ:  if (w_match || w_expire) w_state_nxt = ST_IDLE;
                default:                          w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Issue FSM outputs: FIFO pop, completion strobe and the uP request lines
    always_comb begin
        w_pop      = 1'b0;
        w_done_ack = 1'b0;
        up_rreq    = (r_state == ST_REQ) & ~r_we;
        up_wreq    = (r_state == ST_REQ) & r_we;
        if (!w_abort) begin
            if (r_state == ST_IDLE) begin
                w_pop = ~w_empty;
            end else begin
                w_done_ack = w_match;
            end
        end
    end

    // Load the popped command; reads leave the write channel untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_pop) begin
            r_we   <= r_fifo_we[r_rd_ptr];
            r_addr <= r_fifo_addr[r_rd_ptr];
            if (r_fifo_we[r_rd_ptr]) begin
                r_wdata <= r_fifo_data[r_rd_ptr];
                r_wstrb <= r_fifo_sel[r_rd_ptr];
            end
        end
    end

    // Wishbone ack pulse and read-data capture on a matching uP ack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack    <= 1'b0;
            r_data_o <= '0;
        end else begin
            r_ack <= w_done_ack;
            if (w_done_ack && !r_we) begin
                r_data_o <= up_rdata;
            end
        end
    end
endmodule

// File: tb/tb_up_wishbone_pipelined.sv
// tb/tb_up_wishbone_pipelined.sv - scoreboard bench for up_wishbone_pipelined
`timescale 1ns/1ps
module tb_up_wishbone_pipelined;
    localparam int AW = 16, BW = 4, DW = 32, UAW = 14, DEPTH = 4, TMO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           s_wb_cyc, s_wb_stb, s_wb_we;
    logic [AW-1:0]  s_wb_addr;
    logic [DW-1:0]  s_wb_data_i;
    logic [BW-1:0]  s_wb_sel_i;
    logic           s_wb_stall, s_wb_ack, s_wb_err;
    logic [DW-1:0]  s_wb_data_o;
    logic           up_rreq, up_rack, up_wreq, up_wack;
    logic [UAW-1:0] up_raddr, up_waddr;
    logic [DW-1:0]  up_rdata, up_wdata;
    logic [BW-1:0]  up_wstrb;

    up_wishbone_pipelined #(
        .WISHBONE_ADDRESS_WIDTH(AW), .BUS_WIDTH(BW),
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_wb_cyc(s_wb_cyc), .s_wb_stb(s_wb_stb), .s_wb_we(s_wb_we),
        .s_wb_addr(s_wb_addr), .s_wb_data_i(s_wb_data_i), .s_wb_sel_i(s_wb_sel_i),
        .s_wb_stall(s_wb_stall), .s_wb_ack(s_wb_ack), .s_wb_err(s_wb_err),
        .s_wb_data_o(s_wb_data_o),
        .up_rreq(up_rreq), .up_rack(up_rack), .up_raddr(up_raddr), .up_rdata(up_rdata),
        .up_wreq(up_wreq), .up_wack(up_wack), .up_waddr(up_waddr),
        .up_wdata(up_wdata), .up_wstrb(up_wstrb)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_err; bit is_read; logic [31:0] data; int acc; int lat; } term_t;
    typedef struct { bit we; logic [13:0] addr; logic [31:0] data; logic [3:0] sel; } upx_t;

    term_t       term_q[$];
    upx_t        up_q[$];
    logic [31:0] shadow [64];
    logic [31:0] umem   [64];
    int errors = 0, checks = 0;
    int cyc_n = 0;
    int n_terms = 0, n_exp_terms = 0;
    int burst_acc = 0, first_stall_at = 0;
    int dmin = 1, dmax = 1;
    bit mute_next = 1'b0, stray = 1'b0;
    bit busy = 1'b0, cur_we, cur_mute;
    int cnt;
    logic [13:0] cur_addr;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Reference model: requests complete strictly in acceptance order against a word memory
    task automatic model_accept(input bit we, input logic [15:0] addr, input logic [31:0] data,
                                input logic [3:0] sel, input bit exp_err, input int lat);
        term_t t;
        upx_t  u;
        int    idx;
        idx    = int'(addr[7:2]);
        u.we   = we; u.addr = addr[15:2]; u.data = data; u.sel = sel;
        up_q.push_back(u);
        t.is_err = exp_err; t.is_read = !we; t.data = shadow[idx];
        t.acc = cyc_n + 1; t.lat = lat;
        if (we && !exp_err)
            for (int b = 0; b < 4; b++)
                if (sel[b]) shadow[idx][8*b +: 8] = data[8*b +: 8];
        term_q.push_back(t);
        n_exp_terms++;
    endtask

    task automatic wb_req(input bit we, input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input bit exp_err, input int lat);
        int waited;
        waited = 0;
        @(negedge clk);
        s_wb_stb = 1'b1; s_wb_we = we; s_wb_addr = addr; s_wb_data_i = data; s_wb_sel_i = sel;
        while (s_wb_stall && waited < 100) begin
            if (first_stall_at < 0) first_stall_at = burst_acc;
            @(negedge clk);
            waited++;
        end
        if (s_wb_stall) begin
            chk("accept_timeout", s_wb_stall, 1'b0);
            s_wb_stb = 1'b0;
        end else begin
            model_accept(we, addr, data, sel, exp_err, lat);
            burst_acc++;
            @(posedge clk);
        end
    endtask

    task automatic wb_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_wb_stb = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (term_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", term_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every Wishbone termination is matched against the scoreboard head
    initial begin
        term_t e;
        forever begin
            @(negedge clk);
            if (!rst && (s_wb_ack || s_wb_err)) begin
                n_terms++;
                if (term_q.size() == 0) begin
                    chk("unexpected_termination", {s_wb_ack, s_wb_err}, 2'b00);
                end else begin
                    e = term_q.pop_front();
                    chk("termination_kind", {s_wb_err, s_wb_ack}, e.is_err ? 2'b10 : 2'b01);
                    if (!e.is_err && e.is_read) chk("read_data", s_wb_data_o, e.data);
                    if (e.lat > 0) chk("termination_latency", cyc_n - e.acc, e.lat);
                end
            end
        end
    end

    // uP slave: word memory with a programmable ack delay, checks each request it sees
    initial begin
        upx_t u;
        up_rack = 1'b0; up_wack = 1'b0; up_rdata = '0;
        forever begin
            @(negedge clk);
            up_rack = 1'b0; up_wack = 1'b0;
            if (stray) begin
                up_rack = 1'b1; up_rdata = 32'hDEAD_0001; stray = 1'b0;
            end
            if (!busy) begin
                if (!rst && (up_rreq || up_wreq)) begin
                    chk("single_request_line", up_rreq & up_wreq, 1'b0);
                    if (up_q.size() == 0) begin
                        chk("unexpected_up_request", {up_rreq, up_wreq}, 2'b00);
                    end else begin
                        u = up_q.pop_front();
                        chk("up_direction", up_wreq, u.we);
                        if (u.we) begin
                            chk("up_waddr", up_waddr, u.addr);
                            chk("up_wdata", up_wdata, u.data);
                            chk("up_wstrb", up_wstrb, u.sel);
                        end else begin
                            chk("up_raddr", up_raddr, u.addr);
                        end
                        busy = 1'b1; cur_we = up_wreq; cur_addr = up_wreq ? up_waddr : up_raddr;
                        cur_mute = mute_next; mute_next = 1'b0;
                        cnt = int'($urandom_range(dmax, dmin));
                    end
                end
            end else if (!(up_rreq || up_wreq)) begin
                busy = 1'b0;
            end else begin
                chk("up_addr_held", cur_we ? up_waddr : up_raddr, cur_addr);
                if (!cur_mute) begin
                    if (cnt <= 1) begin
                        if (cur_we) begin
                            up_wack = 1'b1;
                            for (int b = 0; b < 4; b++)
                                if (up_wstrb[b]) umem[up_waddr[5:0]][8*b +: 8] = up_wdata[8*b +: 8];
                        end else begin
                            up_rack  = 1'b1;
                            up_rdata = umem[up_raddr[5:0]];
                        end
                        busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, t0, t;
        for (int i = 0; i < 64; i++) begin
            shadow[i] = '0;
            umem[i]   = '0;
        end
        shadow[2] = 32'hB0BD_BEEF;
        umem[2]   = 32'hB0BD_BEEF;
        rst = 1'b1; s_wb_cyc = 1'b0; s_wb_stb = 1'b0; s_wb_we = 1'b0;
        s_wb_addr = '0; s_wb_data_i = '0; s_wb_sel_i = '0;

        repeat (3) @(negedge clk);
        chk("reset_stall", s_wb_stall, 1'b1);
        chk("reset_ack_err", {s_wb_ack, s_wb_err}, 2'b00);
        chk("reset_req", {up_rreq, up_wreq}, 2'b00);
        chk("reset_data_o", s_wb_data_o, 0);
        chk("reset_raddr", up_raddr, 0);
        chk("reset_waddr", up_waddr, 0);
        chk("reset_wdata", up_wdata, 0);
        chk("reset_wstrb", up_wstrb, 0);
        rst = 1'b0; s_wb_cyc = 1'b1;
        @(negedge clk);
        chk("stall_after_reset", s_wb_stall, 1'b0);

        // Directed single write and read with a one-cycle uP ack
        dmin = 1; dmax = 1;
        wb_req(1'b1, 16'h000C, 32'hAAAA_0000, 4'hF, 1'b0, 3);
        wb_idle(1); drain();
        wb_req(1'b0, 16'h0008, 32'h0, 4'hF, 1'b0, 3);
        wb_idle(1); drain();

        // Back-to-back burst against a slow uP: one entry leaves for the uP at once
        dmin = 5; dmax = 5;
        burst_acc = 0; first_stall_at = -1;
        for (int n = 0; n < 6; n++)
            wb_req(1'b1, 16'(4 * n), 32'hAAAA_0000 + n, 4'hF, 1'b0, 0);
        wb_idle(1); drain();
        chk("accepts_before_stall", first_stall_at, DEPTH + 1);

        // Byte selects on writes; reads return the full word whatever sel says
        dmin = 1; dmax = 1;
        wb_req(1'b1, 16'h0020, 32'h1122_3344, 4'h5, 1'b0, 0);
        wb_req(1'b0, 16'h0023, 32'h0, 4'h0, 1'b0, 0);
        wb_idle(1); drain();

        // Randomized traffic with random uP latency and idle gaps
        dmin = 1; dmax = 4;
        for (int i = 0; i < 40; i++) begin
            wb_req(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom_range(0, 15)), 1'b0, 0);
            gap = int'($urandom_range(0, 2));
            if (gap > 0) wb_idle(gap);
        end
        wb_idle(1); drain();

        // Abort: drop cyc while the first of three reads is outstanding
        dmin = 20; dmax = 20;
        t0 = n_terms;
        wb_req(1'b0, 16'h0010, 32'h0, 4'hF, 1'b0, 0);
        wb_req(1'b0, 16'h0014, 32'h0, 4'hF, 1'b0, 0);
        wb_req(1'b0, 16'h0018, 32'h0, 4'hF, 1'b0, 0);
        wb_idle(1);
        t = 0;
        while (!up_rreq && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("abort_read_issued", up_rreq, 1'b1);
        s_wb_cyc = 1'b0;
        n_exp_terms -= term_q.size();
        term_q.delete();
        up_q.delete();
        @(negedge clk);
        chk("abort_rreq_dropped", up_rreq, 1'b0);
        chk("abort_stall_clear", s_wb_stall, 1'b0);
        stray = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_reissue", {up_rreq, up_wreq}, 2'b00);
        chk("abort_zero_acks", n_terms - t0, 0);
        s_wb_cyc = 1'b1;
        @(negedge clk);

`ifdef UP_WISHBONE_TIMEOUT_EN
        // Unanswered read times out with an error, the following write completes normally
        dmin = 1; dmax = 1;
        mute_next = 1'b1;
        wb_req(1'b0, 16'h0030, 32'h0, 4'hF, 1'b1, TMO + 1);
        wb_req(1'b1, 16'h0034, 32'h5555_AAAA, 4'hF, 1'b0, 0);
        wb_idle(1); drain();
`endif

        repeat (4) @(negedge clk);
        chk("termination_count", n_terms, n_exp_terms);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
